rf_dump_ctrl: RTL
=================

Name: rf_dump_ctrl

Overview:
- Run/halt sequencer for the single-cycle CPU (sccomp_dataflow) used in simulation and board bring-up.
- On start, it enables the CPU for a programmed number of cycles, then freezes it.
- It then walks the register file debug read port and streams all 32 registers out over a valid/ready interface, ending with a done flag.

Parameters:
- CNT_W, 32, width of cycle counter and cycle_limit.
- NREG, 32, number of registers dumped. Index width is fixed at 5 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- cycle_limit  in  CNT_W  number of CPU cycles to execute; sampled on the accepted start.
- inst  in  32  current CPU instruction; used only with the optional feature.
- cpu_en  out  1  CPU clock enable (gates PC and register/memory writes).
- dbg_rf_addr  out  5  register file debug read address.
- dbg_rf_data  in  32  register file debug read data, combinational from dbg_rf_addr.
- out_valid  out  1  dump word available.
- out_ready  in  1  sink accepts word.
- out_idx  out  5  register number of the current word.
- out_data  out  32  register value.
- busy  out  1  high in RUN, HALT, READ and SEND.
- done  out  1  high in DONE.
- cycles_run  out  CNT_W  CPU cycles actually executed in the last or current run.

Behaviour:
- Reset (async, any state): state=IDLE. cpu_en, out_valid, busy and done are 0. dbg_rf_addr, out_idx, out_data and cycles_run are 0. Reset mid-dump abandons the dump with no further beats.
- The counter and limit are CNT_W-bit unsigned. cycles_run increments on each cycle with cpu_en=1 and saturates at all-ones.
- IDLE: on start, latch cycle_limit into lim and clear cycles_run.
  - lim==0: go to HALT.
  - Otherwise: go to RUN.
- RUN: cpu_en=1 combinationally from the state.
  - Leave for HALT on the edge where cycles_run==lim-1, so cpu_en is high for exactly lim cycles.
  - start is ignored here.
- HALT: cpu_en=0. Idx is cleared to 0. One settle cycle, then READ.
- READ: dbg_rf_addr=idx. At the edge, latch dbg_rf_data into out_data and idx into out_idx, then go to SEND.
- SEND: out_valid=1.
  - out_data and out_idx stay stable until the handshake.
  - On out_valid&&out_ready: if idx==NREG-1, go to DONE; otherwise idx+=1 and go to READ.
  - Minimum is 2 cycles per word, so 64 cycles for a full dump with ready tied high.
- DONE: done=1 and cpu_en=0. cycles_run holds its value. start re-arms (same action as in IDLE).
- cpu_en is never high outside RUN. The register file is not written while dumping.
- out_ready is ignored outside SEND.
- start held high continuously: one run per DONE->RUN transition. A new run starts on the first cycle in DONE where start=1.

Optional Feature:
- Macro: RF_DUMP_BREAK_HALT_EN.
- Defined: in RUN, if inst==32'h0000000D (MIPS break) while cpu_en=1, that cycle is the last enabled cycle.
  - The block goes to HALT at that edge, even if cycles_run<lim-1.
  - cycles_run includes the break cycle.
  - The lim limit still applies; the first event to occur wins.
- Not defined: inst is ignored and only the cycle limit ends RUN.

Test Plan:
- rst pulse, then idle 5 cycles -> all outputs 0, state IDLE, cpu_en never high.
- start with cycle_limit=3, out_ready=1 -> cpu_en high exactly 3 consecutive cycles. cycles_run=3. Then 32 beats with out_idx 0..31 and out_data equal to the preloaded registers (reg[i]=32'hA5000000+i). done rises 64 cycles after HALT.
- cycle_limit=0 -> cpu_en never asserted, cycles_run=0, full 32-word dump still produced.
- out_ready toggling 1,0,0,1 during dump -> out_data and out_idx stable while out_valid&&!out_ready. No skipped or duplicated index. Last beat out_idx=31.
- rst asserted during SEND at out_idx=10 -> outputs 0 immediately (async). A new start with cycle_limit=2 runs cleanly from idx 0.
- RF_DUMP_BREAK_HALT_EN defined, cycle_limit=100, inst=32'h0000000D on the 7th enabled cycle -> cpu_en high 7 cycles, cycles_run=7. With the macro undefined, the same stimulus gives cycles_run=100.

Source files
------------

// File: rtl/rf_dump_ctrl.sv
// rtl/rf_dump_ctrl.sv - run/halt sequencer that runs the CPU for a set cycle count, then streams out the register file
// Optional: define RF_DUMP_BREAK_HALT_EN to also end the run on a MIPS break instruction.
module rf_dump_ctrl #(
  parameter int CNT_W = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [31:0]      inst,
  output logic             cpu_en,
  output logic [4:0]       dbg_rf_addr,
  input  logic [31:0]      dbg_rf_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_run
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_HALT, S_READ, S_SEND, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lim;
  logic [4:0]       idx;
  logic             start_ok;
  logic             last_idx;
  logic             brk_hit;
  logic             run_end;

`ifdef RF_DUMP_BREAK_HALT_EN
  assign brk_hit = (inst == 32'h0000_000D);
`else
  logic unused_inst;
  assign unused_inst = ^inst;
  assign brk_hit     = 1'b0;
`endif

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign last_idx = (idx == 5'(NREG - 1));
  // lim is never 0 in RUN, so lim-1 cannot wrap; cpu_en stays high exactly lim cycles
  assign run_end  = (cycles_run == lim - CNT_W'(1)) || brk_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (cycle_limit == '0) ? S_HALT : S_RUN;
      S_RUN:          if (run_end) state_nxt = S_HALT;
      S_HALT:         state_nxt = S_READ;
      S_READ:         state_nxt = S_SEND;
      S_SEND:         if (out_ready) state_nxt = last_idx ? S_DONE : S_READ;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_en      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dbg_rf_addr = 5'd0;
    case (state)
      S_RUN:  begin cpu_en = 1'b1; busy = 1'b1; end
      S_HALT: busy = 1'b1;
      S_READ: begin busy = 1'b1; dbg_rf_addr = idx; end
      S_SEND: begin busy = 1'b1; out_valid = 1'b1; end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim        <= '0;
      cycles_run <= '0;
      idx        <= 5'd0;
      out_idx    <= 5'd0;
      out_data   <= 32'd0;
    end else begin
      if (start_ok) begin
        lim        <= cycle_limit;
        cycles_run <= '0;
      end else if (cpu_en && cycles_run != {CNT_W{1'b1}}) begin
        cycles_run <= cycles_run + CNT_W'(1);
      end
      case (state)
        S_HALT: idx <= 5'd0;
        S_READ: begin
          out_data <= dbg_rf_data;
          out_idx  <= idx;
        end
        S_SEND: if (out_ready && !last_idx) idx <= idx + 5'd1;
        default: ;
      endcase
    end
  end

endmodule
